// File: rtl/multiword_carry_chain_pkg.sv
// Shared types and helpers for the multiword carry-chain adder.
//   state_t   : FSM encoding (IDLE, RUN, DONE)
//   cnt_width : chunk counter width, never less than one bit
package multiword_carry_chain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned num_chunks);
        return (num_chunks <= 1) ? 1 : $clog2(num_chunks);
    endfunction

endpackage

// File: rtl/multiword_carry_chain_adder_chunk_adder.sv
// Combinational CHUNK_WIDTH-bit adder with carry in/out; one chunk of the chain.
// Ports:
//   in1, in2  : chunk operands
//   carryIn   : carry into this chunk
//   out       : low CHUNK_WIDTH bits of the sum
//   carryOut  : carry out of this chunk
module chunk_adder
    import multiword_carry_chain_pkg::*;
#(
    parameter int unsigned CHUNK_WIDTH = 8
) (
    input  logic [CHUNK_WIDTH-1:0] in1,
    input  logic [CHUNK_WIDTH-1:0] in2,
    input  logic                   carryIn,
    output logic [CHUNK_WIDTH-1:0] out,
    output logic                   carryOut
);

    logic [CHUNK_WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, in1} + {1'b0, in2} + {{CHUNK_WIDTH{1'b0}}, carryIn};
    end

    assign out      = sum[CHUNK_WIDTH-1:0];
    assign carryOut = sum[CHUNK_WIDTH];

endmodule

// File: rtl/multiword_carry_chain_adder.sv
// Wide adder that processes one CHUNK_WIDTH slice per cycle, rippling the carry
// between slices through a register. Valid/ready on both sides, no overlap.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   inValid/inReady     : operand handshake (in1, in2, carryIn sampled at accept)
//   outValid/outReady   : result handshake (out, carryOut held in DONE)
//   subtract            : only with MULTIWORD_CARRY_CHAIN_ADD_SUB_EN; inverts in2
// Optional feature macro: MULTIWORD_CARRY_CHAIN_ADD_SUB_EN
module multiword_carry_chain_adder
    import multiword_carry_chain_pkg::*;
#(
    parameter int unsigned CHUNK_WIDTH = 8,
    parameter int unsigned NUM_CHUNKS  = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              inValid,
    output logic                              inReady,
    input  logic [CHUNK_WIDTH*NUM_CHUNKS-1:0] in1,
    input  logic [CHUNK_WIDTH*NUM_CHUNKS-1:0] in2,
    input  logic                              carryIn,
`ifdef MULTIWORD_CARRY_CHAIN_ADD_SUB_EN
    input  logic                              subtract,
`endif
    output logic                              outValid,
    input  logic                              outReady,
    output logic [CHUNK_WIDTH*NUM_CHUNKS-1:0] out,
    output logic                              carryOut
);

    localparam int unsigned W    = CHUNK_WIDTH * NUM_CHUNKS;
    localparam int unsigned CntW = cnt_width(NUM_CHUNKS);
    localparam logic [CntW-1:0] LastChunk = CntW'(NUM_CHUNKS - 1);

    state_t             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]       op1_q, op1_d;
    logic [W-1:0]       op2_q, op2_d;
    logic [W-1:0]       out_q, out_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;

    logic [W-1:0]           in2_eff;
    logic [CHUNK_WIDTH-1:0] a_chunk, b_chunk, s_chunk;
    logic                   s_carry;
    int unsigned            idx;

`ifdef MULTIWORD_CARRY_CHAIN_ADD_SUB_EN
    // Two's-complement subtract: caller supplies the +1 through carryIn.
    assign in2_eff = subtract ? ~in2 : in2;
`else
    assign in2_eff = in2;
`endif

    always_comb begin
        idx     = int'(cnt_q);
        a_chunk = op1_q[idx*CHUNK_WIDTH +: CHUNK_WIDTH];
        b_chunk = op2_q[idx*CHUNK_WIDTH +: CHUNK_WIDTH];
    end

    chunk_adder #(
        .CHUNK_WIDTH (CHUNK_WIDTH)
    ) u_chunk_adder (
        .in1      (a_chunk),
        .in2      (b_chunk),
        .carryIn  (carry_q),
        .out      (s_chunk),
        .carryOut (s_carry)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        out_d   = out_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (inValid) begin
                    op1_d   = in1;
                    op2_d   = in2_eff;
                    carry_d = carryIn;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                out_d[idx*CHUNK_WIDTH +: CHUNK_WIDTH] = s_chunk;
                carry_d = s_carry;
                if (cnt_q == LastChunk) begin
                    cout_d  = s_carry;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (outReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign inReady  = (state_q == IDLE);
    assign outValid = (state_q == DONE);
    assign out      = out_q;
    assign carryOut = cout_q;

endmodule
